fp16_acc: RTL and testbench

FP16_ACC -- requirements
Module: fp16_acc

---
 rtl/fp16_acc_pkg.sv | 19 +
 rtl/fp16_acc_fp16add.sv | 79 +++++++
 rtl/fp16_acc.sv | 82 ++++++++
 tb/tb_fp16_acc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_acc_pkg.sv
// Shared fp16 definitions: field widths, special encodings and the
// accumulator state enum used by the fp16_acc block.
package fp16_acc_pkg;

    localparam int EXP_W  = 5;
    localparam int MANT_W = 10;
    localparam int FP_W   = 1 + EXP_W + MANT_W;

    localparam logic [FP_W-1:0] POS_ZERO = 16'h0000;
    localparam logic [FP_W-1:0] POS_INF  = 16'h7C00;
    localparam logic [FP_W-1:0] NEG_INF  = 16'hFC00;
    localparam logic [FP_W-1:0] QNAN     = 16'h7E00;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;

endpackage

// File: rtl/fp16_acc_fp16add.sv
// Combinational fp16 adder: round-to-nearest-even, denormals flushed to
// signed zero, Inf/NaN propagation (canonical qNaN), overflow to Inf.
module fp16add
    import fp16_acc_pkg::*;
(
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    output logic [FP_W-1:0] o_res
);
    // Wide enough to hold the larger significand shifted by any exponent gap,
    // so the add/sub itself is exact and only the final rounding loses bits.
    localparam int SW = 42;
    localparam int PW = 6;

    function automatic logic [MANT_W:0] rne_frac(input logic [SW-1:0] nrm);
        logic [MANT_W-1:0] frac;
        logic              guard;
        logic              sticky;
        frac   = nrm[SW-2 -: MANT_W];
        guard  = nrm[SW-2-MANT_W];
        sticky = |nrm[SW-3-MANT_W:0];
        return {1'b0, frac} + {{MANT_W{1'b0}}, guard & (sticky | frac[0])};
    endfunction

    logic              sa, sb, sx;
    logic [EXP_W-1:0]  ea, eb, ex, ey, d;
    logic [MANT_W-1:0] ma, mb, mx, my, mo;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, carry;
    logic [SW-1:0]     xv, yv, s, norm;
    logic [PW-1:0]     p;
    logic signed [7:0] be;

    assign sa = i_a[FP_W-1];
    assign ea = i_a[FP_W-2 -: EXP_W];
    assign ma = i_a[MANT_W-1:0];
    assign sb = i_b[FP_W-1];
    assign eb = i_b[FP_W-2 -: EXP_W];
    assign mb = i_b[MANT_W-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (ma == '0);
    assign b_inf  = (eb == '1) && (mb == '0);
    assign a_nan  = (ea == '1) && (ma != '0);
    assign b_nan  = (eb == '1) && (mb != '0);

    always_comb begin
        if ({eb, mb} > {ea, ma}) begin
            sx = sb; ex = eb; mx = mb; ey = ea; my = ma;
        end else begin
            sx = sa; ex = ea; mx = ma; ey = eb; my = mb;
        end
        d  = ex - ey;
        xv = {{(SW-MANT_W-1){1'b0}}, 1'b1, mx} << d;
        yv = {{(SW-MANT_W-1){1'b0}}, 1'b1, my};
        s  = (sa == sb) ? xv + yv : xv - yv;
        p  = '0;
        for (int i = 0; i < SW; i++) begin
            if (s[i]) p = PW'(i);
        end
        norm        = s << (PW'(SW - 1) - p);
        {carry, mo} = rne_frac(norm);
        be = $signed({3'b000, ey}) + $signed({2'b00, p}) - 8'sd10
             + (carry ? 8'sd1 : 8'sd0);

        if (a_nan || b_nan)        o_res = QNAN;
        else if (a_inf && b_inf)   o_res = (sa == sb) ? i_a : QNAN;
        else if (a_inf)            o_res = i_a;
        else if (b_inf)            o_res = i_b;
        else if (a_zero && b_zero) o_res = {sa & sb, {(FP_W-1){1'b0}}};
        else if (a_zero)           o_res = i_b;
        else if (b_zero)           o_res = i_a;
        else if (!norm[SW-1])      o_res = POS_ZERO;
        else if (be <= 8'sd0)      o_res = {sx, {(FP_W-1){1'b0}}};
        else if (be >= 8'sd31)     o_res = sx ? NEG_INF : POS_INF;
        else                       o_res = {sx, be[EXP_W-1:0], mo};
    end

endmodule

// File: rtl/fp16_acc.sv
// Packet accumulator: sums fp16 beats of a packet with a valid/ready
// handshake on both sides and presents the sum plus a saturating beat count.
module fp16_acc
    import fp16_acc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [15:0]      i_data,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [15:0]      o_sum,
    output logic [CNT_W-1:0] o_count
);
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_e            state_q;
    logic [FP_W-1:0]   acc_q, acc_d, add_res;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              first_q, rdy_q, vld_q;

    fp16add u_add (
        .i_a   (acc_q),
        .i_b   (i_data),
        .o_res (add_res)
    );

    always_comb begin
        acc_d = first_q ? i_data : add_res;
        cnt_d = sat_inc(cnt_q);
    end

    // Handshake flags are registered alongside the state so no output
    // depends combinationally on the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= POS_ZERO;
            cnt_q   <= '0;
            first_q <= 1'b1;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    rdy_q <= 1'b1;
                    if (i_valid && rdy_q) begin
                        acc_q   <= acc_d;
                        cnt_q   <= cnt_d;
                        first_q <= 1'b0;
                        if (i_last) begin
                            state_q <= OUT;
                            rdy_q   <= 1'b0;
                            vld_q   <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (i_ready) begin
                        state_q <= ACC;
                        rdy_q   <= 1'b1;
                        vld_q   <= 1'b0;
                        cnt_q   <= '0;
                        first_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_ready = rdy_q;
    assign o_valid = vld_q;
    assign o_sum   = acc_q;
    assign o_count = cnt_q;

endmodule

// File: tb/tb_fp16_acc.sv
// Bench for fp16_acc: directed and randomized packets against a real-valued
// fp16 reference; a CNT_W=2 copy shares the stimulus for count saturation.
module tb_fp16_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_last = 1'b0;
    logic        i_ready = 1'b0;
    logic [15:0] i_data = 16'h0000;
    logic        o_ready, o_valid, o_ready_s, o_valid_s;
    logic [15:0] o_sum, o_sum_s;
    logic [7:0]  o_count;
    logic [1:0]  o_count_s;
    int          n_tests = 0;
    int          n_fail = 0;

    fp16_acc #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_last(i_last), .o_valid(o_valid),
        .i_ready(i_ready), .o_sum(o_sum), .o_count(o_count)
    );

    fp16_acc #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_s),
        .i_data(i_data), .i_last(i_last), .o_valid(o_valid_s),
        .i_ready(i_ready), .o_sum(o_sum_s), .o_count(o_count_s)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (real arithmetic) ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real to_real(input logic [15:0] h);
        int  e = int'(h[14:10]);
        real m;
        if (e == 0) return 0.0;
        m = (1024.0 + real'(h[9:0])) / 1024.0 * pow2(e - 15);
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] from_real(input real r);
        logic s = (r < 0.0);
        real  x = s ? -r : r;
        int   e = 0;
        int   mi;
        real  m, fr;
        if (x == 0.0) return 16'h0000;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        m  = x * 1024.0;
        mi = $rtoi(m);
        fr = m - real'(mi);
        if (fr > 0.5 || (fr == 0.5 && mi[0])) mi++;
        if (mi == 2048) begin mi = 1024; e++; end
        if (e < -14) return {s, 15'd0};
        if (e > 15)  return {s, 5'h1F, 10'd0};
        return {s, 5'(e + 15), 10'(mi - 1024)};
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        logic an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        logic bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        logic ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        logic bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        real  ra, rb;
        if (an || bn) return 16'h7E00;
        if (ai && bi) return (a[15] == b[15]) ? a : 16'h7E00;
        if (ai) return a;
        if (bi) return b;
        ra = to_real(a);
        rb = to_real(b);
        if (ra == 0.0 && rb == 0.0) return {a[15] & b[15], 15'd0};
        return from_real(ra + rb);
    endfunction

    function automatic logic [15:0] ref_pkt(input logic [15:0] q[$]);
        logic [15:0] s = q[0];
        for (int k = 1; k < q.size(); k++) s = ref_add(s, q[k]);
        return s;
    endfunction

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    function automatic logic [15:0] rnd_fp16();
        int sel = int'($urandom_range(0, 9));
        if (sel == 0) return {1'($urandom), 5'd0, 10'($urandom)};
        if (sel == 1) return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
        return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        int g = 0;
        while (o_ready !== 1'b1 && g < 50) begin tick(); g++; end
        chk("beat_ready", 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        tick();
        i_valid = 1'b0;
        i_data  = 16'($urandom);
        i_last  = 1'($urandom);
    endtask

    task automatic send_pkt(input logic [15:0] beats[$], input int stall, input int gaps);
        logic [15:0] es = ref_pkt(beats);
        int          n = beats.size();
        for (int k = 0; k < n; k++) begin
            if (gaps != 0) repeat ($urandom_range(0, 2)) tick();
            beat(beats[k], k == n - 1);
        end
        chk("valid_lat1", 32'(o_valid), 32'd1);
        chk("ready_in_out", 32'(o_ready), 32'd0);
        chk("sum", 32'(o_sum), 32'(es));
        chk("count", 32'(o_count), 32'(sat(n, 255)));
        chk("sum_w2", 32'(o_sum_s), 32'(es));
        chk("count_w2", 32'(o_count_s), 32'(sat(n, 3)));
        for (int c = 0; c < stall; c++) begin
            tick();
            chk("hold_sum", 32'(o_sum), 32'(es));
            chk("hold_count", 32'(o_count), 32'(sat(n, 255)));
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_ready", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("ready_after_hs", 32'(o_ready), 32'd1);
        chk("valid_after_hs", 32'(o_valid), 32'd0);
        chk("count_cleared", 32'(o_count), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] q[$];
        logic [15:0] flat[$];
        logic        lastf[$];
        logic [15:0] exp_s[$];
        int          exp_c[$];
        int          idx, cyc, seen, total, len;
        logic        acc;

        tick();
        tick();
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_sum", 32'(o_sum), 32'h0000);
        chk("rst_count", 32'(o_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(o_ready), 32'd1);

        q = {16'h3C00, 16'h4000, 16'h3C00};
        send_pkt(q, 0, 0);
        chk("basic_sum_const", 32'(ref_pkt(q)), 32'h4400);

        q = {16'h8000};
        send_pkt(q, 5, 0);

        q = {16'h7BFF, 16'h7BFF};
        send_pkt(q, 0, 0);
        q = {16'h7C00, 16'hFC00};
        send_pkt(q, 1, 0);

        // reset in the middle of a packet
        beat(16'h4000, 1'b0);
        beat(16'h4200, 1'b0);
        rst = 1'b1;
        tick();
        chk("midrst_ready", 32'(o_ready), 32'd0);
        chk("midrst_count", 32'(o_count), 32'd0);
        chk("midrst_sum", 32'(o_sum), 32'h0000);
        rst = 1'b0;
        tick();
        q = {16'h4000};
        send_pkt(q, 0, 0);

        // reset while a result is pending
        beat(16'h4400, 1'b1);
        chk("pend_valid", 32'(o_valid), 32'd1);
        rst = 1'b1;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("pendrst_valid", 32'(o_valid), 32'd0);
        chk("pendrst_sum", 32'(o_sum), 32'h0000);
        rst = 1'b0;
        tick();

        q = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        send_pkt(q, 0, 0);

        for (int p = 0; p < 30; p++) begin
            q.delete();
            len = int'($urandom_range(1, 7));
            for (int k = 0; k < len; k++) q.push_back(rnd_fp16());
            send_pkt(q, int'($urandom_range(0, 3)), 1);
        end

        // back-to-back packets, i_valid held high, downstream always ready
        total = 0;
        for (int p = 0; p < 5; p++) begin
            q.delete();
            len = int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) begin
                q.push_back(rnd_fp16());
                flat.push_back(q[k]);
                lastf.push_back(k == len - 1);
            end
            exp_s.push_back(ref_pkt(q));
            exp_c.push_back(len);
            total += len;
        end
        idx = 0; cyc = 0; seen = 0;
        i_ready = 1'b1;
        while (seen < exp_s.size() && cyc < 200) begin
            i_valid = (idx < flat.size());
            i_data  = (idx < flat.size()) ? flat[idx] : 16'h0000;
            i_last  = (idx < flat.size()) ? lastf[idx] : 1'b0;
            acc = o_ready && i_valid;
            tick();
            cyc++;
            if (acc) idx++;
            if (o_valid) begin
                chk("b2b_sum", 32'(o_sum), 32'(exp_s[seen]));
                chk("b2b_count", 32'(o_count), 32'(exp_c[seen]));
                seen++;
            end
        end
        chk("b2b_cycles", 32'(cyc), 32'(total + exp_s.size() - 1));
        chk("b2b_packets", 32'(seen), 32'(exp_s.size()));
        i_valid = 1'b0;
        tick();
        i_ready = 1'b0;
        chk("b2b_end_ready", 32'(o_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
